column_mux_monitor: RTL



---
 rtl/column_mux_monitor.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/column_mux_monitor.sv
// Receive-side checker for the one-hot LED column select bus: decodes the active
// column, strobes on column switches and rotations, and flags encoding/order/dwell faults.
//
// state       | meaning
// ST_IDLE     | bus is zero or illegal, waiting for a one-hot column
// ST_ACQ      | first (partial) column seen, waiting for an in-order switch
// ST_ACQ_GOOD | one in-order switch seen, next in-order in-tolerance switch locks
// ST_LOCKED   | rotation order and dwell time are being enforced
module column_mux_monitor #(
    parameter int EXPECTED_DWELL = 331,
    parameter int DWELL_TOL      = 2,
    parameter int DWELL_BITS     = $clog2(EXPECTED_DWELL + DWELL_TOL + 2)
) (
    input  logic       clk_33,
    input  logic       nrst,
    input  logic [7:0] mux_in,
    input  logic       clr_err,
    output logic [2:0] col_idx,
    output logic       col_valid,
    output logic       col_change,
    output logic       rotation_done,
    output logic       locked,
    output logic       onehot_err,
    output logic       seq_err,
    output logic       dwell_err
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ACQ      = 2'd1,
        ST_ACQ_GOOD = 2'd2,
        ST_LOCKED   = 2'd3
    } state_t;

    localparam logic [DWELL_BITS-1:0] DWELL_MIN   = DWELL_BITS'(EXPECTED_DWELL - DWELL_TOL);
    localparam logic [DWELL_BITS-1:0] DWELL_MAX   = DWELL_BITS'(EXPECTED_DWELL + DWELL_TOL);
    localparam logic [DWELL_BITS-1:0] DWELL_STUCK = DWELL_BITS'(EXPECTED_DWELL + DWELL_TOL + 1);

    state_t                state, state_nxt;
    logic [7:0]            mux_q, mux_prev, mux_exp;
    logic [DWELL_BITS-1:0] dwell_cnt;
    logic                  change, q_onehot, in_tol;
    logic [2:0]            q_idx;
    logic                  col_change_nxt, rot_nxt;
    logic                  onehot_set, seq_set, dwell_set;

    assign change   = (mux_q != mux_prev);
    assign q_onehot = (mux_q != 8'h00) && ((mux_q & (mux_q - 8'h01)) == 8'h00);
    assign mux_exp  = {mux_prev[6:0], mux_prev[7]};
    assign in_tol   = (dwell_cnt >= DWELL_MIN) && (dwell_cnt <= DWELL_MAX);

    always_comb begin
        q_idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (mux_q[i]) q_idx = 3'(i);
        end
    end

    always_ff @(posedge clk_33 or negedge nrst) begin
        if (!nrst) begin
            state     <= ST_IDLE;
            mux_q     <= 8'h00;
            mux_prev  <= 8'h00;
            dwell_cnt <= '0;
        end else begin
            state    <= state_nxt;
            mux_q    <= mux_in;
            mux_prev <= mux_q;
            // dwell_cnt at a change event is the dwell of the column just left
            if (change) begin
                dwell_cnt <= DWELL_BITS'(1);
            end else if (dwell_cnt != '1) begin
                dwell_cnt <= dwell_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt      = state;
        col_change_nxt = 1'b0;
        rot_nxt        = 1'b0;
        onehot_set     = 1'b0;
        seq_set        = 1'b0;
        dwell_set      = 1'b0;
        if (change) begin
            if (mux_q == 8'h00) begin
                state_nxt = ST_IDLE;
            end else if (!q_onehot) begin
                onehot_set = 1'b1;
                state_nxt  = ST_IDLE;
            end else begin
                col_change_nxt = 1'b1;
                case (state)
                    ST_IDLE:     state_nxt = ST_ACQ;
                    ST_ACQ:      state_nxt = (mux_q == mux_exp) ? ST_ACQ_GOOD : ST_ACQ;
                    ST_ACQ_GOOD: state_nxt = (mux_q == mux_exp && in_tol) ? ST_LOCKED : ST_ACQ;
                    ST_LOCKED: begin
                        if (mux_q != mux_exp) begin
                            seq_set   = 1'b1;
                            state_nxt = ST_ACQ;
                        end else if (!in_tol) begin
                            dwell_set = 1'b1;
                            state_nxt = ST_ACQ;
                        end else begin
                            rot_nxt = (mux_q == 8'h01);
                        end
                    end
                    default:     state_nxt = ST_IDLE;
                endcase
            end
        end else if (state == ST_LOCKED && dwell_cnt == DWELL_STUCK) begin
            dwell_set = 1'b1;
            state_nxt = ST_ACQ;
        end
    end

    always_ff @(posedge clk_33 or negedge nrst) begin
        if (!nrst) begin
            col_idx       <= 3'd0;
            col_valid     <= 1'b0;
            col_change    <= 1'b0;
            rotation_done <= 1'b0;
            locked        <= 1'b0;
            onehot_err    <= 1'b0;
            seq_err       <= 1'b0;
            dwell_err     <= 1'b0;
        end else begin
            if (q_onehot) col_idx <= q_idx;
            col_valid     <= q_onehot;
            col_change    <= col_change_nxt;
            rotation_done <= rot_nxt;
            locked        <= (state_nxt == ST_LOCKED);
            // a new error in the same cycle as clr_err leaves the flag set
            onehot_err    <= onehot_set | (onehot_err & ~clr_err);
            seq_err       <= seq_set    | (seq_err    & ~clr_err);
            dwell_err     <= dwell_set  | (dwell_err  & ~clr_err);
        end
    end

endmodule
